gauss_scan_ctrl: RTL
====================

GAUSS_SCAN_CTRL -- requirements
Module: gauss_scan_ctrl

Interface
REQ-001 The block SHALL have parameter FRAME_W, default 200, meaning input frame width in pixels.
REQ-002 The block SHALL have parameter FRAME_H, default 200, meaning input frame height in pixels.
REQ-003 The block SHALL have parameter DOWN_S, default 0, meaning the down-sample exponent: keep 1 of every 2^DOWN_S pixels per axis.
REQ-004 The block SHALL have parameter WIN_RADI, default 9, meaning the vertical Gaussian window radius.
REQ-005 The block SHALL have parameter PIPE_LAT, default 4, meaning the MAC pipeline latency in enabled steps.
REQ-006 Derived values SHALL be DS_W=FRAME_W>>DOWN_S, DS_H=FRAME_H>>DOWN_S and LAG=WIN_RADI*DS_W+PIPE_LAT.
REQ-007 pixClk  input  1  pixel clock; all state updates on its rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 pix_valid  input  1  input pixel present this cycle.
REQ-010 frame_start  input  1  qualifies the current pix_valid pixel as pixel (0,0).
REQ-011 in_ready  output  1  the block accepts pix_valid this cycle.
REQ-012 en_p  output  1  shift enable for the window shift register and the MACs.
REQ-013 pad_zero  output  1  forces the shift-register input pixel to 0.
REQ-014 out_valid  output  1  the MAC output this cycle is a valid filtered pixel.
REQ-015 ox, oy  output  16 each  down-sampled coordinate of the filtered pixel.
REQ-016 out_inner  output  1  the window lies fully inside the image.
REQ-017 frame_done  output  1  one-cycle pulse marking the end of the frame.
REQ-018 err_restart  output  1  one-cycle pulse on a mid-frame restart.

Function
REQ-019 The FSM SHALL have the states IDLE, SCAN, FLUSH and DONE.
REQ-020 In IDLE, when pix_valid&frame_start, the block SHALL count that pixel as (0,0) and move to SCAN; pixels without frame_start SHALL be ignored.
REQ-021 In SCAN, each accepted pixel SHALL advance in_x (wrapping at FRAME_W-1) and advance in_y on that wrap.
REQ-022 In IDLE/SCAN, en_p SHALL equal pix_valid & (in_x low DOWN_S bits==0) & (in_y low DOWN_S bits==0), with pad_zero=0; when DOWN_S=0, en_p SHALL equal pix_valid.
REQ-023 SCAN SHALL move to FLUSH on the accepted pixel (FRAME_W-1, FRAME_H-1).
REQ-024 In FLUSH, in_ready SHALL be 0, and en_p and pad_zero SHALL both be 1 for exactly LAG consecutive cycles, after which the FSM SHALL move to DONE.
REQ-025 In DONE, frame_done SHALL be 1 for one cycle, and the FSM SHALL return to IDLE on the next cycle.
REQ-026 in_ready SHALL be 1 in IDLE and SCAN, and 0 in FLUSH and DONE.
REQ-027 A lag counter SHALL count en_p cycles saturating at LAG; out_valid SHALL be en_p & (lag==LAG), combinationally in the same cycle.
REQ-028 ox/oy SHALL give the coordinate of the current out_valid pixel, then advance after it (ox wraps at DS_W-1, advancing oy); they SHALL hold otherwise.
REQ-029 out_inner SHALL equal (oy>=WIN_RADI)&&(oy<=DS_H-1-WIN_RADI).
REQ-030 Each frame SHALL produce exactly DS_W*DS_H out_valid cycles.
REQ-031 frame_start&pix_valid in SCAN or FLUSH SHALL pulse err_restart, clear all counters, and re-enter SCAN with that pixel as (0,0).
REQ-032 frame_start&pix_valid in DONE SHALL be ignored.

Reset
REQ-033 While rst_n=0, the block SHALL hold state=IDLE, all counters=0, in_ready=1, and all other outputs=0, asynchronously.
REQ-034 Reset deassertion mid-frame SHALL require a new frame_start; no partial-frame output SHALL follow.

Configuration
REQ-035 With GSC_BORDER_MASK_EN defined, out_valid SHALL also require out_inner, so a frame yields DS_W*(DS_H-2*WIN_RADI) valids, while ox/oy still advance on every lagged en_p.
REQ-036 With GSC_BORDER_MASK_EN undefined, out_valid SHALL be as in REQ-027.

Verification (FRAME_W=8, FRAME_H=6, WIN_RADI=1, PIPE_LAT=2)
REQ-037 DOWN_S=0, 48 contiguous pixels -> first out_valid on the 11th en_p at (0,0); 48 valids; FLUSH lasts 10 cycles; frame_done pulses once.
REQ-038 DOWN_S=1, 48 pixels -> 12 en_p in SCAN; LAG=6; 12 valids; last at (3,2).
REQ-039 pix_valid toggled every other cycle -> en_p and out_valid follow pix_valid; ox/oy sequence matches the contiguous case.
REQ-040 frame_start reissued at pixel 20 -> err_restart pulses once; the following frame yields 48 valids starting at (0,0).
REQ-041 rst_n low during FLUSH -> outputs 0 immediately; no frame_done until a new frame completes.
REQ-042 GSC_BORDER_MASK_EN defined, DOWN_S=0 -> 32 valids, first at (0,1), last at (7,4).

Source files
------------

// File: rtl/gauss_scan_ctrl.sv
// rtl/gauss_scan_ctrl.sv - scan/flush sequencer for a vertical Gaussian window with MAC pipeline.
// Optional build macro GSC_BORDER_MASK_EN suppresses out_valid for rows whose window crosses the border.
module gauss_scan_ctrl #(
   parameter int FRAME_W  = 200,
   parameter int FRAME_H  = 200,
   parameter int DOWN_S   = 0,
   parameter int WIN_RADI = 9,
   parameter int PIPE_LAT = 4
) (
   input  logic        pixClk,
   input  logic        rst_n,
   input  logic        pix_valid,
   input  logic        frame_start,
   output logic        in_ready,
   output logic        en_p,
   output logic        pad_zero,
   output logic        out_valid,
   output logic [15:0] ox,
   output logic [15:0] oy,
   output logic        out_inner,
   output logic        frame_done,
   output logic        err_restart
);

   localparam int DS_W = FRAME_W >> DOWN_S;
   localparam int DS_H = FRAME_H >> DOWN_S;
   localparam int LAG  = WIN_RADI * DS_W + PIPE_LAT;

   localparam logic [15:0] DS_MASK  = 16'((1 << DOWN_S) - 1);
   localparam logic [15:0] W_LAST   = 16'(FRAME_W - 1);
   localparam logic [15:0] H_LAST   = 16'(FRAME_H - 1);
   localparam logic [15:0] DSW_LAST = 16'(DS_W - 1);
   localparam logic [15:0] DSH_LAST = 16'(DS_H - 1);
   localparam logic [15:0] LAG_V    = 16'(LAG);
   localparam logic [15:0] LAG_LAST = 16'(LAG - 1);
   localparam logic [15:0] INNER_LO = 16'(WIN_RADI);
   localparam logic [15:0] INNER_HI = 16'(DS_H - 1 - WIN_RADI);

   typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

   state_t      state, nextState;
   logic [15:0] inX, inY, lag, flushCnt;
   logic [15:0] curX, curY;
   logic        accept, frameGo, lastPix, lagged;

   always_comb begin
      nextState   = state;
      in_ready    = (state == IDLE) || (state == SCAN);
      en_p        = 1'b0;
      pad_zero    = 1'b0;
      frame_done  = 1'b0;
      err_restart = 1'b0;
      accept      = 1'b0;
      frameGo     = 1'b0;
      curX        = inX;
      curY        = inY;
      lastPix     = 1'b0;
      if (rst_n) begin
         case (state)
            IDLE: begin
               if (pix_valid && frame_start) begin
                  frameGo = 1'b1;
                  accept  = 1'b1;
               end
            end
            SCAN: begin
               if (pix_valid) begin
                  accept = 1'b1;
                  if (frame_start) begin
                     frameGo     = 1'b1;
                     err_restart = 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (pix_valid && frame_start) begin
                  frameGo     = 1'b1;
                  accept      = 1'b1;
                  err_restart = 1'b1;
               end else begin
                  en_p     = 1'b1;
                  pad_zero = 1'b1;
                  if (flushCnt == LAG_LAST) nextState = DONE;
               end
            end
            DONE: begin
               frame_done = 1'b1;
               nextState  = IDLE;
            end
            default: nextState = IDLE;
         endcase
         // A starting or restarting pixel is always coordinate (0,0).
         if (frameGo) begin
            curX = '0;
            curY = '0;
         end
         lastPix = (curX == W_LAST) && (curY == H_LAST);
         if (accept) begin
            en_p      = ((curX & DS_MASK) == '0) && ((curY & DS_MASK) == '0);
            nextState = lastPix ? FLUSH : SCAN;
         end
      end
   end

   // The pixel that opens a frame never emits: the lag counter still holds the previous frame's value.
   assign lagged    = en_p && (lag == LAG_V) && !frameGo;
   assign out_inner = (oy >= INNER_LO) && (oy <= INNER_HI);

`ifdef GSC_BORDER_MASK_EN
   assign out_valid = lagged && out_inner;
`else
   assign out_valid = lagged;
`endif

   always_ff @(posedge pixClk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         inX      <= '0;
         inY      <= '0;
         lag      <= '0;
         flushCnt <= '0;
         ox       <= '0;
         oy       <= '0;
      end else begin
         state <= nextState;

         if (accept) begin
            if (curX == W_LAST) begin
               inX <= '0;
               inY <= (curY == H_LAST) ? 16'd0 : curY + 16'd1;
            end else begin
               inX <= curX + 16'd1;
               inY <= curY;
            end
         end

         if ((state == FLUSH) && !frameGo)
            flushCnt <= (flushCnt == LAG_LAST) ? 16'd0 : flushCnt + 16'd1;
         else
            flushCnt <= '0;

         if (frameGo)
            lag <= 16'd1;
         else if (en_p && (lag != LAG_V))
            lag <= lag + 16'd1;

         // Output coordinates follow every lagged step, masked or not.
         if (frameGo) begin
            ox <= '0;
            oy <= '0;
         end else if (lagged) begin
            if (ox == DSW_LAST) begin
               ox <= '0;
               oy <= (oy == DSH_LAST) ? 16'd0 : oy + 16'd1;
            end else begin
               ox <= ox + 16'd1;
            end
         end
      end
   end

endmodule
